// File: rtl/shift_deser.sv
// Serial-to-parallel receiver: start-bit framed, LSB-first word delivered on a valid/ready port.
// Optional even-parity bit after the data bits when SHIFT_DESER_PARITY_EN is defined.
module shift_deser #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             shift_in,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic             parity_err,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
`ifdef SHIFT_DESER_PARITY_EN
    localparam logic [1:0] S_PAR  = 2'd2;
`endif

    logic [1:0]       state;
    logic [BW-1:0]    cnt;
    logic [WIDTH-1:0] asm_q;
    logic [WIDTH-1:0] asm_next;
    logic [WIDTH-1:0] word;
    logic             done;
`ifdef SHIFT_DESER_PARITY_EN
    logic             bad;
`endif

    // Completion is decided on the edge that samples the last bit, so the
    // delivered word includes the bit arriving on that same edge.
    always_comb begin
        asm_next      = asm_q;
        asm_next[cnt] = shift_in;
        word          = asm_next;
        done          = 1'b0;
`ifdef SHIFT_DESER_PARITY_EN
        bad           = 1'b0;
        if (state == S_PAR) begin
            done = 1'b1;
            word = asm_q;
            bad  = (^asm_q) ^ shift_in;
        end
`else
        if (state == S_DATA && cnt == LAST) begin
            done = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= S_IDLE;
            cnt       <= '0;
            asm_q     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (shift_in) begin
                        state <= S_DATA;
                        cnt   <= '0;
                    end
                end
                S_DATA: begin
                    asm_q <= asm_next;
                    cnt   <= cnt + BW'(1);
                    if (cnt == LAST) begin
`ifdef SHIFT_DESER_PARITY_EN
                        state <= S_PAR;
`else
                        state <= S_IDLE;
`endif
                    end
                end
`ifdef SHIFT_DESER_PARITY_EN
                S_PAR: state <= S_IDLE;
`endif
                default: state <= S_IDLE;
            endcase

            if (done) begin
                if (!out_valid || out_ready) begin
                    out_data  <= word;
                    out_valid <= 1'b1;
                    frame_cnt <= frame_cnt + CNT_W'(1);
                end else begin
                    overflow <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef SHIFT_DESER_PARITY_EN
    always_ff @(posedge clk) begin
        if (clr) begin
            parity_err <= 1'b0;
        end else if (done && bad) begin
            parity_err <= 1'b1;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_deser.sv
// Directed bench for shift_deser at WIDTH=8; parity cases run when SHIFT_DESER_PARITY_EN is defined.
module tb_shift_deser;

    localparam int W     = 8;
    localparam int CNT_W = 16;
`ifdef SHIFT_DESER_PARITY_EN
    localparam int FLEN  = W + 2;
`else
    localparam int FLEN  = W + 1;
`endif

    logic             clk = 1'b0;
    logic             clr;
    logic             shift_in;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic             out_valid;
    logic             overflow;
    logic             parity_err;
    logic [CNT_W-1:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    shift_deser #(.WIDTH(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .clr        (clr),
        .shift_in   (shift_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .parity_err (parity_err),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read there too.
    task automatic send_bit(input logic b);
        shift_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clr      = 1'b1;
        shift_in = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic send_partial(input logic [W-1:0] d, input int n);
        send_bit(1'b1);
        for (int i = 0; i < n; i++) send_bit(d[i]);
    endtask

    // rdy_last: 0/1 drives out_ready just before the final bit edge, 2 leaves it alone.
    task automatic send_frame(input logic [W-1:0] d, input logic flip, input int rdy_last);
        logic [W+1:0] bits;
        bits = {(^d) ^ flip, d, 1'b1};
        for (int i = 0; i < FLEN; i++) begin
            if (i == FLEN - 1 && rdy_last < 2) out_ready = (rdy_last == 1);
            send_bit(bits[i]);
        end
        shift_in = 1'b0;
    endtask

    initial begin
        clr       = 1'b0;
        shift_in  = 1'b0;
        out_ready = 1'b0;
        #1;

        // Reset state
        do_clear();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'h0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_perr", 64'(parity_err), 64'd0);
        check("rst_cnt", 64'(frame_cnt), 64'd0);

        // 0xA5 with latency check, out_ready low
`ifdef SHIFT_DESER_PARITY_EN
        send_frame(8'hA5, 1'b0, 2);
`else
        send_partial(8'hA5, W - 1);
        check("a5_early_valid", 64'(out_valid), 64'd0);
        send_bit(1'b1);
        shift_in = 1'b0;
`endif
        check("a5_valid", 64'(out_valid), 64'd1);
        check("a5_data", 64'(out_data), 64'hA5);
        check("a5_cnt", 64'(frame_cnt), 64'd1);
        send_bit(1'b0);
        check("a5_hold_data", 64'(out_data), 64'hA5);
        out_ready = 1'b1;
        send_bit(1'b0);
        check("a5_accept", 64'(out_valid), 64'd0);
        out_ready = 1'b0;
        send_bit(1'b0);
        check("ready_no_effect", 64'(out_valid), 64'd0);

        // Back-to-back frames, consumer always ready
        do_clear();
        out_ready = 1'b1;
        send_frame(8'h3C, 1'b0, 2);
        check("b2b_v1", 64'(out_valid), 64'd1);
        check("b2b_d1", 64'(out_data), 64'h3C);
        send_bit(1'b1);
        check("b2b_gap_valid", 64'(out_valid), 64'd0);
        for (int i = 1; i < FLEN; i++) begin
            logic [W+1:0] bits;
            bits = {^8'hC3, 8'hC3, 1'b1};
            send_bit(bits[i]);
        end
        shift_in = 1'b0;
        check("b2b_v2", 64'(out_valid), 64'd1);
        check("b2b_d2", 64'(out_data), 64'hC3);
        check("b2b_cnt", 64'(frame_cnt), 64'd2);
        check("b2b_ovf", 64'(overflow), 64'd0);
        send_bit(1'b0);
        check("b2b_drain", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // Overflow when holding register is full
        do_clear();
        send_frame(8'h11, 1'b0, 0);
        send_frame(8'h22, 1'b0, 0);
        check("ovf_data", 64'(out_data), 64'h11);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_cnt", 64'(frame_cnt), 64'd1);
        check("ovf_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        send_bit(1'b0);
        out_ready = 1'b0;
        check("ovf_accept", 64'(out_valid), 64'd0);
        check("ovf_sticky", 64'(overflow), 64'd1);

        // Accept on the same edge as completion
        do_clear();
        send_frame(8'h11, 1'b0, 0);
        send_frame(8'h22, 1'b0, 1);
        out_ready = 1'b0;
        check("sim_data", 64'(out_data), 64'h22);
        check("sim_valid", 64'(out_valid), 64'd1);
        check("sim_ovf", 64'(overflow), 64'd0);
        check("sim_cnt", 64'(frame_cnt), 64'd2);

        // Clear mid-frame aborts the partial word
        do_clear();
        send_partial(8'hFF, 4);
        clr = 1'b1;
        send_bit(1'b1);
        clr      = 1'b0;
        shift_in = 1'b0;
        check("clr_mid_valid", 64'(out_valid), 64'd0);
        check("clr_mid_cnt", 64'(frame_cnt), 64'd0);
        send_frame(8'h01, 1'b0, 2);
        check("clr_data", 64'(out_data), 64'h01);
        check("clr_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 12; i++) send_bit(1'b0);
        check("clr_cnt", 64'(frame_cnt), 64'd1);
        check("clr_ovf", 64'(overflow), 64'd0);

`ifdef SHIFT_DESER_PARITY_EN
        do_clear();
        out_ready = 1'b1;
        send_frame(8'h07, 1'b0, 2);
        check("par_ok_perr", 64'(parity_err), 64'd0);
        check("par_ok_data", 64'(out_data), 64'h07);
        send_frame(8'h07, 1'b1, 2);
        check("par_bad_perr", 64'(parity_err), 64'd1);
        check("par_bad_data", 64'(out_data), 64'h07);
        check("par_bad_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b0;
        send_bit(1'b0);
        check("par_sticky", 64'(parity_err), 64'd1);
`else
        check("perr_tied", 64'(parity_err), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_deser.md
# shift_deser

Serial-to-parallel receiver for the single-bit shift chain. It samples the serial stream arriving from the far end of a shift register chain and detects a start-bit framed word. It assembles the word LSB-first and presents it on a parallel valid/ready output port. It is the consumer at the `shift_out` end of a chain whose `shift_in` end is driven by a framing source.

## Interface

- `WIDTH`, default 32: data bits per frame; legal range 2..64.
- `CNT_W`, default 16: width of the received-frame counter.
- `clk` in 1: sole clock; all logic is on the rising edge.
- `clr` in 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `shift_in` in 1: serial line, sampled every rising edge; idle level 0.
- `out_data` out WIDTH: received word, `out_data[0]` = first data bit received.
- `out_valid` out 1: `out_data` holds an unconsumed word.
- `out_ready` in 1: consumer accepts the word on an edge where `out_valid && out_ready`.
- `overflow` out 1: sticky; a completed frame was dropped because the holding register was full.
- `parity_err` out 1: sticky; a frame failed the parity check. It is constant 0 when parity is compiled out.
- `frame_cnt` out CNT_W: count of frames loaded into `out_data`; wraps modulo 2^CNT_W.

## Operation

- Frame format: one start bit (1), WIDTH data bits LSB-first, then one even-parity bit if `SHIFT_DESER_PARITY_EN` is defined. There is no stop bit.
- FSM states: IDLE, DATA, PAR. PAR is present only with the macro.
- IDLE: `shift_in`=1 → DATA with bit counter cleared. `shift_in`=0 → stay in IDLE.
- DATA: each edge shifts `shift_in` into the assembly register at index = bit counter, then increments the counter.
  - After the WIDTH-th data bit, go to PAR if the macro is defined.
  - Otherwise go to IDLE and complete the frame.
- PAR: sample the parity bit, go to IDLE and complete the frame.
  - The frame is bad if the XOR of the data bits and the parity bit is 1.
  - A bad frame sets `parity_err` and the word is still delivered.
- Frame completion, on the same edge as the last sampled bit:
  - If `out_valid`=0, or `out_valid`=1 with `out_ready`=1 on that edge: load `out_data`, set `out_valid`=1, increment `frame_cnt`.
  - If `out_valid`=1 with `out_ready`=0: drop the new word and set `overflow`. `out_data`, `out_valid` and `frame_cnt` are unchanged.
- Handshake:
  - Without completion: `out_valid && out_ready` clears `out_valid` on that edge.
  - `out_data` is stable while `out_valid`=1 and not accepted.
  - `out_ready` while `out_valid`=0 has no effect.
- Back-to-back frames: the edge after completion is in IDLE, so the next start bit may arrive on the very next cycle. There is zero idle gap between frames.
- Clear: `clr`=1 on any edge, including mid-frame, aborts the frame. It forces IDLE and counter 0 in that cycle regardless of `shift_in`.

## Timing

- Reset values: `out_data`=0, `out_valid`=0, `overflow`=0, `parity_err`=0, `frame_cnt`=0, FSM=IDLE.
- Start bit sampled at edge k; data bit i sampled at edge k+1+i.
- Without parity: `out_valid` rises after edge k+WIDTH; latency from start bit is WIDTH+1 edges.
- With parity: the parity bit is sampled at edge k+WIDTH+1; `out_valid` rises after that edge.
- All outputs are registered. There is no combinational path from `shift_in` or `out_ready` to any output.
- Sticky flags remain set until `clr`.

## Configuration

- `SHIFT_DESER_PARITY_EN` defined:
  - PAR state exists.
  - Frame length is WIDTH+2 bits.
  - `parity_err` is live.
- `SHIFT_DESER_PARITY_EN` undefined:
  - No PAR state.
  - Frame length is WIDTH+1 bits.
  - `parity_err` is tied to 0.
- The port list is identical in both builds.

## Test plan

- Reset, WIDTH=8, no parity: assert `clr` for 2 cycles → all outputs 0. Then send 1 followed by 0xA5 LSB-first (1,0,1,0,0,1,0,1) with `out_ready`=0 → after the 9th edge `out_valid`=1, `out_data`=0xA5, `frame_cnt`=1.
- Back-to-back, `out_ready`=1: send frames 0x3C and 0xC3 with no gap.
  - `out_valid` asserts for 1 cycle with 0x3C, then 1 cycle with 0xC3.
  - `frame_cnt`=2, `overflow`=0.
- Overflow: `out_ready`=0, send 0x11 then 0x22 → `out_data` stays 0x11, `overflow`=1, `frame_cnt`=1. Then `out_ready`=1 for one cycle → `out_valid`=0 and `overflow` stays 1.
- Simultaneous accept and completion: hold 0x11, raise `out_ready` exactly on the last-bit edge of 0x22 → `out_data`=0x22, `out_valid`=1, `overflow`=0.
- Clear mid-frame: start 0xFF, assert `clr` after 4 data bits, then send 0x01 cleanly → only 0x01 is delivered, `frame_cnt`=1.
- Parity build, WIDTH=8:
  - Send 0x07 with parity 1 → `parity_err`=0.
  - Send 0x07 with parity 0 → `parity_err`=1 and `out_data`=0x07.
